// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if: bundles the execute-side branch handshake, the BTB
// write port, the fetch redirect and the status outputs of btb_update_ctrl.
//   slave  : the controller side (consumes branches, drives the BTB write port)
//   master : the environment side (execute stage, BTB, fetch)
//   ex_*        branch resolved by execute, accepted on ex_valid & ex_ready
//   wr_*        BTB write port, a write is consumed on wr_en & wr_ready
//   redirect*   one-cycle fetch redirect pulse and its target
//   init_busy   BTB clear walk in progress
//   fifo_count  pending updates held in the controller
interface btb_update_ctrl_if #(
  parameter int DEPTH = 4
);
  logic                   ex_valid;
  logic [31:0]            ex_pc;
  logic [31:0]            ex_target;
  logic                   ex_taken;
  logic                   ex_pred_hit;
  logic [31:0]            ex_pred_target;
  logic                   ex_ready;
  logic                   wr_en;
  logic [3:0]             wr_index;
  logic                   wr_busy;
  logic [25:0]            wr_tag;
  logic [31:0]            wr_target;
  logic                   wr_ready;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   init_busy;
  logic [$clog2(DEPTH):0] fifo_count;

  modport slave (
    input  ex_valid, ex_pc, ex_target, ex_taken, ex_pred_hit, ex_pred_target,
    input  wr_ready,
    output ex_ready,
    output wr_en, wr_index, wr_busy, wr_tag, wr_target,
    output redirect, redirect_pc, init_busy, fifo_count
  );

  modport master (
    output ex_valid, ex_pc, ex_target, ex_taken, ex_pred_hit, ex_pred_target,
    output wr_ready,
    input  ex_ready,
    input  wr_en, wr_index, wr_busy, wr_tag, wr_target,
    input  redirect, redirect_pc, init_busy, fifo_count
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: clears the BTB after reset, then turns resolved branches
// into BTB allocate/invalidate writes through a small FIFO and raises a fetch
// redirect for every mispredicted branch.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active high
//   bus    btb_update_ctrl_if.slave (branch input, BTB write port, redirect,
//          init_busy, fifo_count)
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | walk init_ptr over all BTB lines writing busy=0, no branches taken
// RUN   | accept branches, drain update FIFO into the BTB write port
module btb_update_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = 16
) (
  input logic              clk,
  input logic              reset,
  btb_update_ctrl_if.slave bus
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [3:0]  LAST_IDX = 4'(ENTRIES - 1);
  localparam logic [PW:0] FULL     = (PW+1)'(DEPTH);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic        busy;
    logic [3:0]  index;
    logic [25:0] tag;
    logic [31:0] target;
  } upd_t;

  state_t        state_q, state_d;
  logic [3:0]    init_ptr_q, init_ptr_d;
  upd_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          redirect_q;
  logic [31:0]   redirect_pc_q;

  logic accept, mispredict, do_alloc, do_inval, push, pop;
  upd_t push_entry, head;

  assign head = mem[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    bus.ex_ready  = 1'b0;
    bus.init_busy = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_index  = '0;
    bus.wr_busy   = 1'b0;
    bus.wr_tag    = '0;
    bus.wr_target = '0;
    case (state_q)
      INIT: begin
        bus.init_busy = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_index  = init_ptr_q;
        if (bus.wr_ready) begin
          if (init_ptr_q == LAST_IDX) begin
            state_d    = RUN;
            init_ptr_d = '0;
          end else begin
            init_ptr_d = init_ptr_q + 4'd1;
          end
        end
      end
      RUN: begin
        // Readiness looks at the registered count only, so a full FIFO
        // stays closed even in a cycle where the head is being consumed.
        bus.ex_ready  = (count_q < FULL);
        bus.wr_en     = (count_q != '0);
        bus.wr_index  = head.index;
        bus.wr_busy   = head.busy;
        bus.wr_tag    = head.tag;
        bus.wr_target = head.target;
      end
    endcase
  end

  always_comb begin
    accept     = bus.ex_valid && bus.ex_ready;
    mispredict = (bus.ex_taken != bus.ex_pred_hit) ||
                 (bus.ex_taken && bus.ex_pred_hit && (bus.ex_pred_target != bus.ex_target));
    do_alloc   = accept && bus.ex_taken && mispredict;
    do_inval   = accept && !bus.ex_taken && bus.ex_pred_hit;
    push       = do_alloc || do_inval;
    pop        = (state_q == RUN) && bus.wr_en && bus.wr_ready;

    push_entry       = '0;
    push_entry.index = bus.ex_pc[5:2];
    if (do_alloc) begin
      push_entry.busy   = 1'b1;
      push_entry.tag    = bus.ex_pc[31:6];
      push_entry.target = bus.ex_target;
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      count_q    <= count_d;
      if (push) begin
        mem[wr_ptr_q] <= push_entry;
        wr_ptr_q      <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      redirect_q <= accept && mispredict;
      if (accept && mispredict) begin
        redirect_pc_q <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
      end
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        busy;
    logic [3:0]  index;
    logic [25:0] tag;
    logic [31:0] target;
  } upd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  upd_t exp_q[$];

  btb_update_ctrl_if #(.DEPTH(DEPTH)) bus ();

  btb_update_ctrl #(.DEPTH(DEPTH), .ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic hit, input logic [31:0] pt);
    bus.ex_valid       = v;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_taken       = tk;
    bus.ex_pred_hit    = hit;
    bus.ex_pred_target = pt;
  endtask

  function automatic upd_t observed();
    return {bus.wr_busy, bus.wr_index, bus.wr_tag, bus.wr_target};
  endfunction

  // Reference model of one accepted branch: queues the expected BTB write
  // (if any), returns whether a redirect is due and its target.
  function automatic logic model_accept(output logic [31:0] rpc);
    logic mis;
    mis = (bus.ex_taken != bus.ex_pred_hit) ||
          (bus.ex_taken && bus.ex_pred_hit && (bus.ex_pred_target != bus.ex_target));
    rpc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    if (bus.ex_taken && mis)
      exp_q.push_back({1'b1, bus.ex_pc[5:2], bus.ex_pc[31:6], bus.ex_target});
    else if (!bus.ex_taken && bus.ex_pred_hit)
      exp_q.push_back({1'b0, bus.ex_pc[5:2], 26'd0, 32'd0});
    return mis;
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.wr_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    got = {bus.wr_en, bus.wr_index, bus.wr_busy, bus.init_busy, bus.ex_ready};
    checks++;
    if (got !== {1'b1, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", got, {1'b1, 4'd0, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_fifo_count: got %0d expected 0", bus.fifo_count);
    end
    checks++;
    if ({bus.redirect, bus.redirect_pc} !== 33'd0) begin
      errors++;
      $display("FAIL reset_redirect: got %b/%h expected 0/00000000", bus.redirect, bus.redirect_pc);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.wr_index, bus.init_busy} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL init_stall: got index %0d busy %b expected index 0 busy 1", bus.wr_index, bus.init_busy);
    end
    next_cycle();
  endtask

  task automatic test_init_walk();
    logic [9:0] got, exp;
    bus.wr_ready = 1'b1;
    bus.ex_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got = {bus.wr_en, bus.wr_index, bus.wr_busy, bus.init_busy, bus.ex_ready, |bus.wr_tag, |bus.wr_target};
      exp = {1'b1, 4'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL init_walk_%0d: got %b expected %b", i, got, exp);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({bus.init_busy, bus.ex_ready, bus.wr_en, bus.fifo_count} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL init_done: got busy %b ready %b wr_en %b count %0d expected 0 1 0 0",
               bus.init_busy, bus.ex_ready, bus.wr_en, bus.fifo_count);
    end
    next_cycle();
  endtask

  task automatic test_allocate();
    bus.wr_ready = 1'b1;
    drive(1'b1, 32'h0000_0048, 32'h0000_0100, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL alloc_ready: got %b expected 1", bus.ex_ready);
    end
    next_cycle();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL alloc_redirect: got %b/%h expected 1/00000100", bus.redirect, bus.redirect_pc);
    end
    checks++;
    if ({bus.wr_en, observed()} !== {1'b1, 1'b1, 4'd2, 26'd1, 32'h100}) begin
      errors++;
      $display("FAIL alloc_write: got en %b %h expected en 1 %h", bus.wr_en, observed(),
               {1'b1, 4'd2, 26'd1, 32'h100});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.redirect, bus.redirect_pc, bus.fifo_count, bus.wr_en} !== {1'b0, 32'h100, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL alloc_after: got redir %b pc %h count %0d wr_en %b expected 0 00000100 0 0",
               bus.redirect, bus.redirect_pc, bus.fifo_count, bus.wr_en);
    end
    next_cycle();
  endtask

  task automatic test_invalidate();
    bus.wr_ready = 1'b1;
    drive(1'b1, 32'h0000_0010, 32'h0000_0800, 1'b0, 1'b1, 32'h0000_0800);
    next_cycle();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'h14}) begin
      errors++;
      $display("FAIL inval_redirect: got %b/%h expected 1/00000014", bus.redirect, bus.redirect_pc);
    end
    checks++;
    if ({bus.wr_en, observed()} !== {1'b1, 1'b0, 4'd4, 26'd0, 32'd0}) begin
      errors++;
      $display("FAIL inval_write: got en %b %h expected en 1 %h", bus.wr_en, observed(),
               {1'b0, 4'd4, 26'd0, 32'd0});
    end
    next_cycle();
  endtask

  task automatic test_correct_pred();
    bus.wr_ready = 1'b1;
    drive(1'b1, 32'h0000_0200, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0400);
    next_cycle();
    drive(1'b1, 32'h0000_0204, 32'h0000_0500, 1'b0, 1'b0, 32'h0000_0600);
    @(negedge clk);
    checks++;
    if ({bus.redirect, bus.redirect_pc, bus.fifo_count, bus.wr_en} !== {1'b0, 32'h14, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL correct_taken: got redir %b pc %h count %0d wr_en %b expected 0 00000014 0 0",
               bus.redirect, bus.redirect_pc, bus.fifo_count, bus.wr_en);
    end
    next_cycle();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.redirect, bus.fifo_count, bus.wr_en} !== {1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL correct_not_taken: got redir %b count %0d wr_en %b expected 0 0 0",
               bus.redirect, bus.fifo_count, bus.wr_en);
    end
    next_cycle();
  endtask

  task automatic test_wrong_target();
    bus.wr_ready = 1'b1;
    drive(1'b1, 32'h0000_0084, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0304);
    next_cycle();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL wrong_tgt_redirect: got %b/%h expected 1/00000300", bus.redirect, bus.redirect_pc);
    end
    checks++;
    if ({bus.wr_en, observed()} !== {1'b1, 1'b1, 4'd1, 26'd2, 32'h300}) begin
      errors++;
      $display("FAIL wrong_tgt_write: got en %b %h expected en 1 %h", bus.wr_en, observed(),
               {1'b1, 4'd1, 26'd2, 32'h300});
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic        exp_rd, mis, took5;
    logic [31:0] rpc;
    upd_t        e;
    took5 = 1'b0;
    bus.wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h0000_1000 + 32'(k * 4), 32'h0000_8000 + 32'(k * 64), 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.ex_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_fill_ready_%0d: got %b expected 1", k, bus.ex_ready);
      end
      mis = model_accept(rpc);
      next_cycle();
    end
    drive(1'b1, 32'h0000_003C, 32'h0000_9000, 1'b0, 1'b1, 32'h0000_9000);
    @(negedge clk);
    checks++;
    if ({bus.fifo_count, bus.ex_ready, bus.wr_en} !== {3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_full: got count %0d ready %b wr_en %b expected 4 0 1",
               bus.fifo_count, bus.ex_ready, bus.wr_en);
    end
    next_cycle();
    bus.wr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_rd = (exp_q.size() < DEPTH);
      checks++;
      if ({bus.ex_ready, bus.fifo_count} !== {exp_rd, 3'(exp_q.size())}) begin
        errors++;
        $display("FAIL bp_drain_ready_%0d: got ready %b count %0d expected %b %0d",
                 c, bus.ex_ready, bus.fifo_count, exp_rd, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.wr_en, observed()} !== {1'b1, e}) begin
          errors++;
          $display("FAIL bp_drain_write_%0d: got en %b %h expected en 1 %h", c, bus.wr_en, observed(), e);
        end
      end
      if (bus.ex_valid && exp_rd) begin
        mis = model_accept(rpc);
        took5 = 1'b1;
      end
      next_cycle();
      if (took5) bus.ex_valid = 1'b0;
      if (took5 && exp_q.size() == 0) break;
    end
    @(negedge clk);
    checks++;
    if (!took5 || exp_q.size() != 0 || bus.fifo_count !== 3'd0 || bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain_end: got count %0d wr_en %b pending %0d accepted5 %b expected 0 0 0 1",
               bus.fifo_count, bus.wr_en, exp_q.size(), took5);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic        exp_rd, exp_redir, mis;
    logic [31:0] exp_rpc, rpc;
    upd_t        e;
    exp_redir = 1'b0;
    exp_rpc   = 32'h0;
    for (int c = 0; c < 320; c++) begin
      if (c < 300) begin
        bus.ex_valid       = ($urandom_range(0, 3) != 0);
        bus.ex_pc          = $urandom;
        bus.ex_target      = $urandom;
        bus.ex_taken       = 1'($urandom_range(0, 1));
        bus.ex_pred_hit    = 1'($urandom_range(0, 1));
        bus.ex_pred_target = ($urandom_range(0, 1) != 0) ? bus.ex_target : $urandom;
        bus.wr_ready       = ($urandom_range(0, 2) != 0);
      end else begin
        bus.ex_valid = 1'b0;
        bus.wr_ready = 1'b1;
      end
      @(negedge clk);
      exp_rd = (exp_q.size() < DEPTH);
      checks++;
      if ({bus.ex_ready, bus.fifo_count, bus.wr_en} !== {exp_rd, 3'(exp_q.size()), exp_q.size() != 0}) begin
        errors++;
        $display("FAIL b2b_status_%0d: got ready %b count %0d wr_en %b expected %b %0d %b",
                 c, bus.ex_ready, bus.fifo_count, bus.wr_en, exp_rd, exp_q.size(), exp_q.size() != 0);
      end
      checks++;
      if (bus.redirect !== exp_redir || (exp_redir && bus.redirect_pc !== exp_rpc)) begin
        errors++;
        $display("FAIL b2b_redirect_%0d: got %b/%h expected %b/%h", c, bus.redirect, bus.redirect_pc,
                 exp_redir, exp_rpc);
      end
      if (bus.wr_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL b2b_write_%0d: got %h expected %h", c, observed(), e);
        end
      end
      exp_redir = 1'b0;
      if (bus.ex_valid && exp_rd) begin
        mis = model_accept(rpc);
        exp_redir = mis;
        exp_rpc   = rpc;
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_drain_end: got count %0d pending %0d expected 0 0", bus.fifo_count, exp_q.size());
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic        mis;
    logic [31:0] rpc;
    bus.wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_4000 + 32'(k * 4), 32'h0000_A000 + 32'(k * 4), 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      mis = model_accept(rpc);
      next_cycle();
    end
    drive(1'b1, 32'h0000_5000, 32'h0000_B000, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.fifo_count, bus.ex_ready} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre_reset: got count %0d ready %b expected 3 1", bus.fifo_count, bus.ex_ready);
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.ex_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({bus.fifo_count, bus.redirect, bus.redirect_pc} !== {3'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL mid_reset_state: got count %0d redir %b pc %h expected 0 0 00000000",
               bus.fifo_count, bus.redirect, bus.redirect_pc);
    end
    checks++;
    if ({bus.wr_en, bus.wr_index, bus.wr_busy, bus.init_busy, bus.ex_ready} !== {1'b1, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_init: got en %b idx %0d busy %b init %b ready %b expected 1 0 0 1 0",
               bus.wr_en, bus.wr_index, bus.wr_busy, bus.init_busy, bus.ex_ready);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_init_walk();
    test_allocate();
    test_invalidate();
    test_correct_pred();
    test_wrong_target();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_init_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of update-FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter ENTRIES, 16, number of BTB lines walked during init.
REQ-003 SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have input reset, 1 bit, synchronous active-high reset.
REQ-005 SHALL have input ex_valid, 1 bit, execute stage presents a resolved branch.
REQ-006 SHALL have inputs ex_pc and ex_target, each 32 bits, giving the branch PC and the resolved target.
REQ-007 SHALL have input ex_taken, 1 bit, the actual branch outcome.
REQ-008 SHALL have inputs ex_pred_hit (1 bit) and ex_pred_target (32 bits), giving the prediction made at fetch.
REQ-009 SHALL have output ex_ready, 1 bit; a branch is accepted when ex_valid and ex_ready are both 1.
REQ-010 SHALL have outputs wr_en (1), wr_index (4), wr_busy (1), wr_tag (26) and wr_target (32), forming the BTB write port.
REQ-011 SHALL have input wr_ready, 1 bit; the BTB consumes a write when wr_en and wr_ready are both 1.
REQ-012 SHALL have outputs redirect (1) and redirect_pc (32), the fetch redirect request.
REQ-013 SHALL have outputs init_busy (1) and fifo_count ($clog2(DEPTH)+1 bits).

Function
REQ-014 SHALL implement exactly two states:
- INIT: clear the BTB.
- RUN: normal operation.
REQ-015 INIT SHALL drive wr_en=1, wr_busy=0, wr_tag=0, wr_target=0 and wr_index=init_ptr.
- init_ptr starts at 0 and advances only on a consumed write.
- After the write at ENTRIES-1 is consumed: INIT->RUN, and init_ptr wraps to 0.
REQ-016 In INIT, ex_ready SHALL be 0 and init_busy SHALL be 1; in RUN, init_busy SHALL be 0.
REQ-017 In RUN, ex_ready SHALL be 1 iff fifo_count < DEPTH.
- ex_ready depends on fifo_count only; a same-cycle pop does not free a slot for a push.
REQ-018 On acceptance, mispredict SHALL be computed as (ex_taken != ex_pred_hit) OR (ex_taken AND ex_pred_hit AND ex_pred_target != ex_target).
REQ-019 On acceptance, an update SHALL be pushed into the FIFO as follows:
- Allocate {busy=1, index=ex_pc[5:2], tag=ex_pc[31:6], target=ex_target} when ex_taken and mispredict.
- Invalidate {busy=0, index=ex_pc[5:2], tag=0, target=0} when not ex_taken and ex_pred_hit.
- Otherwise nothing is pushed.
REQ-020 In RUN, wr_en SHALL equal (fifo_count != 0), with the write-port fields driven from the FIFO head.
- The head is popped when wr_en and wr_ready are both 1.
- Order is strictly FIFO; no coalescing of same-index updates.
REQ-021 A pushed update SHALL appear on the write port no earlier than the cycle after acceptance; there is no empty-FIFO bypass.
REQ-022 redirect SHALL be a one-cycle pulse registered in the cycle after an accepted mispredicted branch.
- redirect_pc = ex_target if ex_taken, else ex_pc+4 (modulo 2^32).
- redirect_pc holds its last value while redirect=0.
REQ-023 Push and pop in the same cycle SHALL leave fifo_count unchanged and SHALL preserve order.
REQ-024 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-025 Write-port fields SHALL hold stable while wr_en=1 and wr_ready=0.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set:
- state=INIT, init_ptr=0
- FIFO pointers=0, fifo_count=0
- redirect=0, redirect_pc=0
REQ-027 Reset SHALL take priority over all other events, including an in-progress INIT walk, a pending FIFO entry and a simultaneous acceptance; pending updates are discarded.
REQ-028 In the cycle after reset deasserts, the block SHALL show wr_en=1, wr_index=0, wr_busy=0, init_busy=1 and ex_ready=0.

Verification
REQ-029 Init walk: reset, then wr_ready=1 constantly -> wr_index steps 0..15 on consecutive cycles; init_busy falls after 16 writes; ex_ready=1 the next cycle.
REQ-030 Allocate: in RUN, accept ex_pc=0x0000_0048, ex_taken=1, ex_pred_hit=0, ex_target=0x0000_0100 -> next cycle redirect=1, redirect_pc=0x100, wr_en=1, wr_index=2, wr_tag=1, wr_busy=1, wr_target=0x100.
REQ-031 Invalidate: accept ex_pc=0x0000_0010, ex_taken=0, ex_pred_hit=1 -> redirect_pc=0x14, write of index 4 with busy=0.
REQ-032 Backpressure: wr_ready=0 and 4 mispredicts accepted -> fifo_count=4 and ex_ready=0; with the 5th branch held and wr_ready=1 -> 4 writes drain in order, and ex_ready returns to 1 once fifo_count=3.
REQ-033 Correct prediction: accept ex_taken=1, ex_pred_hit=1, ex_pred_target=ex_target -> no redirect, no push, fifo_count unchanged.
REQ-034 Reset mid-operation: assert reset with fifo_count=3 during a wr_ready=0 stall -> next cycle fifo_count=0, redirect=0 and the INIT walk restarts at index 0.
